// File: rtl/esm_issue_scheduler_if.sv
// Handshake bundle between the decode/execute side and the ESM issue scheduler.
// The master drives allocation, issue accept and completion. The slave is the scheduler.
interface esm_issue_scheduler_if #(
  parameter int BS     = 16,
  parameter int REGNUM = 16
);
  localparam int IW = $clog2(BS);
  localparam int RW = $clog2(REGNUM);

  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_rd;
  logic          in_rd_we;
  logic [RW-1:0] in_rs1;
  logic [RW-1:0] in_rs2;
  logic          in_rs1_en;
  logic          in_rs2_en;
  logic [IW-1:0] alloc_index;
  logic          iss_valid;
  logic [IW-1:0] iss_index;
  logic          iss_ready;
  logic          cmp_valid;
  logic [IW-1:0] cmp_index;
  logic          ret_valid;
  logic [IW-1:0] ret_index;
  logic [IW:0]   count;
  logic          empty;
  logic          full;

  modport master (
    output in_valid, in_rd, in_rd_we, in_rs1, in_rs2, in_rs1_en, in_rs2_en,
           iss_ready, cmp_valid, cmp_index,
    input  in_ready, alloc_index, iss_valid, iss_index, ret_valid, ret_index,
           count, empty, full
  );

  modport slave (
    input  in_valid, in_rd, in_rd_we, in_rs1, in_rs2, in_rs1_en, in_rs2_en,
           iss_ready, cmp_valid, cmp_index,
    output in_ready, alloc_index, iss_valid, iss_index, ret_valid, ret_index,
           count, empty, full
  );
endinterface

// File: rtl/esm_issue_scheduler.sv
// Out-of-order issue scheduler: RAW/WAW dependence masks per slot, oldest-ready issue,
// and in-order retire from head. alloc_index is the tail pointer that feeds the IRT table.
module esm_issue_scheduler #(
  parameter int BS     = 16,
  parameter int REGNUM = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  esm_issue_scheduler_if.slave sch
);
  localparam int IW = $clog2(BS);
  localparam int RW = $clog2(REGNUM);
  localparam logic [IW:0] FULL_CNT = (IW+1)'(BS);

  logic [BS-1:0] valid_q;
  logic [BS-1:0] issued_q;
  logic [BS-1:0] done_q;
  logic [BS-1:0] we_q;
  logic [RW-1:0] rd_q  [BS];
  logic [BS-1:0] dep_q [BS];
  logic [IW-1:0] head_q;
  logic [IW-1:0] tail_q;
  logic [IW:0]   count_q;

  logic          alloc;
  logic          iss_fire;
  logic          cmp_ok;
  logic          retire;
  logic [BS-1:0] ready;
  logic [BS-1:0] new_dep;
  logic          iss_found;
  logic [IW-1:0] iss_sel;
  logic [IW-1:0] scan_idx;

  assign sch.full        = (count_q == FULL_CNT);
  assign sch.empty       = (count_q == '0);
  assign sch.in_ready    = !sch.full;
  assign sch.count       = count_q;
  assign sch.alloc_index = tail_q;

  assign alloc  = sch.in_valid && sch.in_ready;
  assign cmp_ok = sch.cmp_valid && valid_q[sch.cmp_index] && issued_q[sch.cmp_index]
                  && !done_q[sch.cmp_index];
  assign retire = valid_q[head_q] && done_q[head_q];

  assign sch.ret_valid = retire;
  assign sch.ret_index = head_q;

  always_comb begin
    ready = '0;
    for (int i = 0; i < BS; i++) begin
      ready[i] = valid_q[i] && !issued_q[i] && (dep_q[i] == '0);
    end
  end

  // Age-ordered scan starting at head; the first hit is the oldest ready entry.
  always_comb begin
    iss_found = 1'b0;
    iss_sel   = '0;
    scan_idx  = '0;
    for (int k = 0; k < BS; k++) begin
      scan_idx = head_q + IW'(k);
      if (!iss_found && ready[scan_idx]) begin
        iss_found = 1'b1;
        iss_sel   = scan_idx;
      end
    end
  end

  assign sch.iss_valid = iss_found;
  assign sch.iss_index = iss_sel;
  assign iss_fire      = iss_found && sch.iss_ready;

  // Register 0 never creates a dependence; a producer completing this cycle is bypassed.
  always_comb begin
    new_dep = '0;
    for (int j = 0; j < BS; j++) begin
      new_dep[j] = valid_q[j] && !done_q[j] && we_q[j] && (rd_q[j] != '0)
                   && !(cmp_ok && (sch.cmp_index == IW'(j)))
                   && ((sch.in_rs1_en && (rd_q[j] == sch.in_rs1))
                    || (sch.in_rs2_en && (rd_q[j] == sch.in_rs2))
                    || (sch.in_rd_we  && (rd_q[j] == sch.in_rd)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      issued_q <= '0;
      done_q   <= '0;
      we_q     <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < BS; i++) begin
        rd_q[i]  <= '0;
        dep_q[i] <= '0;
      end
    end else begin
      if (cmp_ok) begin
        done_q[sch.cmp_index] <= 1'b1;
        for (int i = 0; i < BS; i++) begin
          dep_q[i][sch.cmp_index] <= 1'b0;
        end
      end
      if (iss_fire) begin
        issued_q[iss_sel] <= 1'b1;
      end
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + IW'(1);
      end
      // Tail slot is free here, so this write never collides with issue/complete/retire.
      if (alloc) begin
        valid_q[tail_q]  <= 1'b1;
        issued_q[tail_q] <= 1'b0;
        done_q[tail_q]   <= 1'b0;
        we_q[tail_q]     <= sch.in_rd_we;
        rd_q[tail_q]     <= sch.in_rd;
        dep_q[tail_q]    <= new_dep;
        tail_q           <= tail_q + IW'(1);
      end
      count_q <= count_q + (IW+1)'(alloc) - (IW+1)'(retire);
    end
  end
endmodule
